// File: rtl/alu_pkg.sv
// Shared encodings for the accumulator ALU and the sequencer that drives it.
// Latency: none, definitions only.
// Backpressure: none; consumers own all flow control.
package alu_pkg;

  // ALU operation codes presented on alu_control
  localparam logic [2:0] ALU_PASS = 3'd0;  // AC <= in2
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_MUL  = 3'd3;
  localparam logic [2:0] ALU_INC  = 3'd4;
  localparam logic [2:0] ALU_CLR  = 3'd5;

  // Instruction opcodes (ir[15:12]); 0xB..0xE are illegal
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_MUL   = 4'h5;
  localparam logic [3:0] OP_INC   = 4'h6;
  localparam logic [3:0] OP_CLR   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JMPZ  = 4'h9;
  localparam logic [3:0] OP_JMPNZ = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_DECODE,
    S_MEMRD,
    S_EXEC,
    S_STORE,
    S_HALT,
    S_ERROR
  } seq_state_t;

  typedef struct packed {
    logic [2:0] alu_control;
    logic       needs_mem;
    logic       is_alu;
    logic       is_jump;
    logic       illegal;
  } op_dec_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle between the sequencer and its instruction ROM, data memory and ALU.
// Latency: ROM data returns one cycle after imem_addr; ALU answers via ac_load.
// Backpressure: the ALU holds the sequencer in EXEC by withholding ac_load.
interface alu_sequencer_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_rdata;
  logic [ADDR_W-1:0] dmem_addr;
  logic              dmem_we;
  logic [2:0]        alu_control;
  logic              zflag;
  logic              ac_load;

  modport master (
    output imem_addr, dmem_addr, dmem_we, alu_control,
    input  imem_rdata, zflag, ac_load
  );

  modport slave (
    input  imem_addr, dmem_addr, dmem_we, alu_control,
    output imem_rdata, zflag, ac_load
  );
endinterface

// File: rtl/alu_op_decoder.sv
// Maps an opcode to its ALU code and instruction-class flags.
// Latency: purely combinational.
// Backpressure: none.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [3:0] opcode,
  output op_dec_t    dec
);

  // Classify the opcode; anything not listed is illegal
  always_comb begin
    dec = '0;
    case (opcode)
      OP_NOP, OP_STORE, OP_HALT: ;
      OP_LOAD: begin dec.alu_control = ALU_PASS; dec.needs_mem = 1'b1; dec.is_alu = 1'b1; end
      OP_ADD:  begin dec.alu_control = ALU_ADD;  dec.needs_mem = 1'b1; dec.is_alu = 1'b1; end
      OP_SUB:  begin dec.alu_control = ALU_SUB;  dec.needs_mem = 1'b1; dec.is_alu = 1'b1; end
      OP_MUL:  begin dec.alu_control = ALU_MUL;  dec.needs_mem = 1'b1; dec.is_alu = 1'b1; end
      OP_INC:  begin dec.alu_control = ALU_INC;  dec.is_alu = 1'b1; end
      OP_CLR:  begin dec.alu_control = ALU_CLR;  dec.is_alu = 1'b1; end
      OP_JMP, OP_JMPZ, OP_JMPNZ: dec.is_jump = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the accumulator ALU.
// Latency: NOP/jump 3 cycles, STORE 4, INC/CLR 3+k, memory ALU ops 4+k.
// Backpressure: waits in EXEC for ac_load, errors after ALU_TIMEOUT cycles.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int OPC_W       = 4,
  parameter int START_ADDR  = 0,
  parameter int ALU_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  alu_sequencer_if.master bus,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int IR_W  = OPC_W + ADDR_W;
  localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

  seq_state_t        state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [IR_W-1:0]   ir, ir_nxt;
  logic              z_reg, z_nxt;
  logic [CNT_W-1:0]  tmo_cnt, tmo_cnt_nxt;

  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] operand;
  op_dec_t           dec;
  logic [ADDR_W-1:0] dmem_addr;
  logic              dmem_we;
  logic [2:0]        alu_control;

  assign opcode  = ir[IR_W-1 -: OPC_W];
  assign operand = ir[ADDR_W-1:0];

  alu_op_decoder u_dec (
    .opcode (opcode),
    .dec    (dec)
  );

  assign bus.imem_addr   = pc;
  assign bus.dmem_addr   = dmem_addr;
  assign bus.dmem_we     = dmem_we;
  assign bus.alu_control = alu_control;

  // State and datapath registers; rst wins in every state, including EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= START_PC;
      ir      <= '0;
      z_reg   <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      ir      <= ir_nxt;
      z_reg   <= z_nxt;
      tmo_cnt <= tmo_cnt_nxt;
    end
  end

  // Next-state and output decode; the timeout counter only runs in EXEC
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ir_nxt      = ir;
    z_nxt       = z_reg;
    tmo_cnt_nxt = '0;
    dmem_addr   = '0;
    dmem_we     = 1'b0;
    alu_control = ALU_PASS;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      S_IDLE, S_HALT: begin
        done = (state == S_HALT);
        if (start) begin
          pc_nxt    = START_PC;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        busy      = 1'b1;
        state_nxt = S_LATCH;
      end
      S_LATCH: begin
        busy      = 1'b1;
        ir_nxt    = bus.imem_rdata;
        pc_nxt    = pc + ADDR_W'(1);  // wraps at the top of the address space
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        busy = 1'b1;
        if (dec.illegal) begin
          state_nxt = S_ERROR;
        end else if (dec.is_alu) begin
          state_nxt = dec.needs_mem ? S_MEMRD : S_EXEC;
        end else if (opcode == OP_STORE) begin
          state_nxt = S_STORE;
        end else if (opcode == OP_HALT) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_FETCH;
          if (dec.is_jump && ((opcode == OP_JMP) ||
                              (opcode == OP_JMPZ  &&  z_reg) ||
                              (opcode == OP_JMPNZ && !z_reg)))
            pc_nxt = operand;
        end
      end
      S_MEMRD: begin
        busy      = 1'b1;
        dmem_addr = operand;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        busy        = 1'b1;
        dmem_addr   = operand;
        alu_control = dec.alu_control;
        if (bus.ac_load) begin
          z_nxt     = bus.zflag;
          state_nxt = S_FETCH;
        end else if (tmo_cnt == CNT_LAST) begin
          state_nxt = S_ERROR;
        end else begin
          tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
        end
      end
      S_STORE: begin
        busy      = 1'b1;
        dmem_addr = operand;
        dmem_we   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_ERROR: begin
        err = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed programs against an instruction-level timing model of the sequencer.
// Latency: checks every cycle from start to HALT/ERROR.
// Backpressure: ALU responder holds ac_load high (k=1) or low (timeout).
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int AW  = 12;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst, start, zf, al;
  logic busy, done, err;

  alu_sequencer_if #(.ADDR_W(AW)) bus ();

  alu_sequencer #(
    .ADDR_W      (AW),
    .OPC_W       (4),
    .START_ADDR  (0),
    .ALU_TIMEOUT (TMO)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  assign bus.zflag   = zf;
  assign bus.ac_load = al;

  logic [15:0] imem [0:4095];

  // Synchronous instruction ROM
  always @(posedge clk) bus.imem_rdata <= imem[bus.imem_addr];

  typedef struct packed {
    logic        chk_pc;
    logic [11:0] pc;
    logic        chk_da;
    logic [11:0] da;
    logic        we;
    logic [2:0]  alu;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  exp_t expq[$];
  exp_t cur;
  logic armed = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [11:0] log_ia [0:63];
  logic [11:0] log_da [0:63];
  logic [2:0]  log_alu[0:63];
  logic        log_we [0:63];
  logic        log_done[0:63];
  logic        log_err[0:63];

  task automatic check(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", nm, c, act, exp_v);
    end
  endtask

  function automatic int alu_code(input int op);
    case (op)
      1: return 0;
      3: return 1;
      4: return 2;
      5: return 3;
      6: return 4;
      7: return 5;
      default: return 0;
    endcase
  endfunction

  task automatic push(input bit cp, input int p, input bit cd, input int d, input bit we,
                      input int alu, input bit b, input bit dn, input bit e);
    exp_t r;
    r.chk_pc = cp;  r.pc = p[11:0];
    r.chk_da = cd;  r.da = d[11:0];
    r.we = we;      r.alu = alu[2:0];
    r.busy = b;     r.done = dn;  r.err = e;
    expq.push_back(r);
  endtask

  // Instruction-level model: each instruction contributes its cycles from the latency rules
  task automatic build_model(input bit zfv, input bit alv, input int max_cyc);
    int pc; bit z; bit stop; logic [15:0] w; int op; int a; int code;
    pc = 0; z = 1'b0; stop = 1'b0;
    expq.delete();
    while (!stop && expq.size() < max_cyc) begin
      w  = imem[pc];
      op = int'(w[15:12]);
      a  = int'(w[11:0]);
      push(1'b1, pc, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
      push(1'b0, 0,  1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
      push(1'b0, 0,  1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
      pc = (pc + 1) % 4096;
      if (op == 1 || (op >= 3 && op <= 7)) begin
        code = alu_code(op);
        if (op <= 5) push(1'b0, 0, 1'b1, a, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        if (alv) begin
          push(1'b0, 0, 1'b1, a, 1'b0, code, 1'b1, 1'b0, 1'b0);
          z = zfv;
        end else begin
          for (int t = 0; t < TMO; t++) push(1'b0, 0, 1'b1, a, 1'b0, code, 1'b1, 1'b0, 1'b0);
          push(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
          stop = 1'b1;
        end
      end else if (op == 2) begin
        push(1'b0, 0, 1'b1, a, 1'b1, 0, 1'b1, 1'b0, 1'b0);
      end else if (op == 8) begin
        pc = a;
      end else if (op == 9) begin
        if (z) pc = a;
      end else if (op == 10) begin
        if (!z) pc = a;
      end else if (op == 15) begin
        push(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        stop = 1'b1;
      end else if (op != 0) begin
        push(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        stop = 1'b1;
      end
    end
  endtask

  // Per-cycle compare of DUT outputs against the model queue
  always @(negedge clk) begin
    if (!armed) begin
      cyc = 0;
    end else if (expq.size() > 0) begin
      cur = expq.pop_front();
      cyc = cyc + 1;
      if (cyc < 64) begin
        log_ia[cyc]   = bus.imem_addr;
        log_da[cyc]   = bus.dmem_addr;
        log_alu[cyc]  = bus.alu_control;
        log_we[cyc]   = bus.dmem_we;
        log_done[cyc] = done;
        log_err[cyc]  = err;
      end
      check("busy", cyc, busy, cur.busy);
      check("done", cyc, done, cur.done);
      check("err", cyc, err, cur.err);
      check("dmem_we", cyc, bus.dmem_we, cur.we);
      check("alu_control", cyc, bus.alu_control, cur.alu);
      if (cur.chk_pc) check("imem_addr", cyc, bus.imem_addr, cur.pc);
      if (cur.chk_da) check("dmem_addr", cyc, bus.dmem_addr, cur.da);
    end
  end

  task automatic clear_imem();
    for (int i = 0; i < 4096; i++) imem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Pulse start, then let the compare process drain the model queue
  task automatic run(input bit zc, input int zcyc, input int restart_at, input int limit);
    zf = (zcyc > 0) ? 1'b0 : zc;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    armed = 1'b1;
    for (int n = 1; n <= limit && expq.size() > 0; n++) begin
      start = (n == restart_at);
      zf    = (zcyc > 0) ? (n == zcyc) : zc;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    armed = 1'b0;
    check("queue_drained", 0, expq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wes;
    rst = 1'b1; start = 1'b0; zf = 1'b0; al = 1'b0;
    clear_imem();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 0, busy, 0);
    check("rst_done", 0, done, 0);
    check("rst_err", 0, err, 0);
    check("rst_alu", 0, bus.alu_control, 0);
    check("rst_we", 0, bus.dmem_we, 0);
    check("rst_imem_addr", 0, bus.imem_addr, 0);
    check("rst_dmem_addr", 0, bus.dmem_addr, 0);
    rst = 1'b0;

    // LOAD/ADD/STORE/HALT with a start pulse while busy
    clear_imem();
    imem[0] = 16'h1010; imem[1] = 16'h3011; imem[2] = 16'h2012; imem[3] = 16'hF000;
    al = 1'b1;
    build_model(1'b0, 1'b1, 40);
    check("model_len_prog", 0, expq.size(), 18);
    run(1'b0, 0, 7, 60);
    check("load_alu_pass", 5, log_alu[5], 0);
    check("add_alu_add", 10, log_alu[10], 1);
    check("store_we", 14, log_we[14], 1);
    check("store_addr", 14, log_da[14], 12'h012);
    check("done_not_yet", 17, log_done[17], 0);
    check("done_at_17", 18, log_done[18], 1);
    wes = 0;
    for (int i = 1; i <= 18; i++) wes += int'(log_we[i]);
    check("we_pulses", 0, wes, 1);
    do_reset();

    // SUB with zero result, JMPZ taken; zflag only high during EXEC
    clear_imem();
    imem[0] = 16'h4030; imem[1] = 16'h9020; imem[2] = 16'hF000; imem[12'h020] = 16'hF000;
    build_model(1'b1, 1'b1, 40);
    run(1'b0, 5, 0, 60);
    check("sub_alu", 5, log_alu[5], 2);
    check("jmpz_taken", 9, log_ia[9], 12'h020);
    do_reset();

    // Same program, nonzero result, JMPZ falls through
    build_model(1'b0, 1'b1, 40);
    run(1'b0, 0, 0, 60);
    check("jmpz_not_taken", 9, log_ia[9], 12'h002);
    do_reset();

    // JMPNZ not taken at 0xFFF wraps the pc to 0x000
    clear_imem();
    imem[0] = 16'h4030; imem[1] = 16'h8FFF; imem[12'hFFF] = 16'hA100;
    build_model(1'b1, 1'b1, 14);
    run(1'b1, 0, 0, 60);
    check("fetch_fff", 9, log_ia[9], 12'hFFF);
    check("wrap_to_0", 12, log_ia[12], 12'h000);
    do_reset();

    // ALU never answers: error 8 cycles after EXEC entry
    clear_imem();
    imem[0] = 16'h3011;
    al = 1'b0;
    build_model(1'b0, 1'b0, 40);
    check("model_len_tmo", 0, expq.size(), 13);
    run(1'b0, 0, 0, 60);
    check("tmo_alu_add", 5, log_alu[5], 1);
    check("tmo_err_early", 12, log_err[12], 0);
    check("tmo_err_on_time", 13, log_err[13], 1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("err_sticky", 0, err, 1);
    check("err_not_busy", 0, busy, 0);
    do_reset();
    @(negedge clk);
    check("rst_clears_err", 0, err, 0);

    // rst mid-EXEC returns straight to IDLE
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 12 && bus.alu_control != 3'd1; i++) @(negedge clk);
    check("exec_reached", 0, bus.alu_control, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midexec_alu", 0, bus.alu_control, 0);
    check("midexec_busy", 0, busy, 0);
    check("midexec_err", 0, err, 0);
    check("midexec_imem_addr", 0, bus.imem_addr, 0);
    rst = 1'b0;

    // Illegal opcode 0xB at address 0
    clear_imem();
    imem[0] = 16'hB000;
    al = 1'b1;
    build_model(1'b0, 1'b1, 40);
    check("model_len_ill", 0, expq.size(), 4);
    run(1'b0, 0, 0, 20);
    check("ill_err_decode", 3, log_err[3], 0);
    check("ill_err_after", 4, log_err[4], 1);
    wes = 0;
    for (int i = 1; i <= 4; i++) wes += int'(log_we[i]);
    check("ill_no_we", 0, wes, 0);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle control unit that sits on the opposite side of the ALU control interface from the ALU. It fetches instructions from a synchronous instruction ROM and decodes them. It drives alu_control, waits for the ALU's ac_load handshake, and captures zflag for conditional jumps. It also generates data-memory addresses and write strobes for the matrix-multiplier datapath.

Parameters:
ADDR_W, 12, instruction/data memory address width and operand field width
OPC_W, 4, opcode field width; OPC_W+ADDR_W must equal 16 (instruction word)
START_ADDR, 0, PC value loaded on start
ALU_TIMEOUT, 15, max cycles to wait for ac_load before error

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins execution from START_ADDR when idle or halted
imem_addr  out  ADDR_W  instruction ROM address (= PC)
imem_rdata  in  16  instruction word, valid one cycle after imem_addr
dmem_addr  out  ADDR_W  data memory address (operand field)
dmem_we  out  1  data memory write strobe (writes AC externally)
alu_control  out  3  ALU operation code
zflag  in  1  ALU zero flag, valid when ac_load=1
ac_load  in  1  ALU result-valid/accumulator-load handshake
busy  out  1  high from start until HALT or ERROR
done  out  1  high in HALT until next start or reset
err  out  1  high in ERROR; cleared only by rst

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; pc=START_ADDR; ir=0; z_reg=0; timeout counter=0. All outputs 0, except imem_addr=pc. rst overrides every state, including mid-EXEC.
- ALU codes: PASS=0 (AC<=in2), ADD=1, SUB=2, MUL=3, INC=4, CLR=5. alu_control=0 outside EXEC.
- Instruction: opcode=ir[15:12], operand=ir[11:0].
- Opcodes: 0 NOP; 1 LOAD a; 2 STORE a; 3 ADD a; 4 SUB a; 5 MUL a; 6 INC; 7 CLR; 8 JMP a; 9 JMPZ a; A JMPNZ a; F HALT. Opcodes B-E are illegal and go to ERROR.
- FSM states: IDLE, FETCH, LATCH, DECODE, MEMRD, EXEC, STORE, HALT, ERROR.
- IDLE/HALT: on start, pc<=START_ADDR, go to FETCH, busy=1, done=0.
- start while busy: ignored.
- FETCH: imem_addr=pc, held for 1 cycle, then LATCH.
- LATCH: ir<=imem_rdata; pc<=pc+1, wrapping modulo 2^ADDR_W (0xFFF -> 0x000); then DECODE.
- DECODE (1 cycle):
  - NOP -> FETCH.
  - LOAD/ADD/SUB/MUL -> MEMRD.
  - INC/CLR -> EXEC.
  - STORE -> STORE.
  - JMP: pc<=operand, -> FETCH.
  - JMPZ: if z_reg then pc<=operand; -> FETCH.
  - JMPNZ: if !z_reg then pc<=operand; -> FETCH.
  - HALT -> HALT (busy=0, done=1).
  - Illegal -> ERROR.
- MEMRD: dmem_addr=operand for 1 cycle (sync read), then EXEC. dmem_addr keeps the operand through EXEC.
- EXEC: alu_control=mapped code, held constant; counter increments each cycle.
  - On ac_load=1: z_reg<=zflag, counter<=0, -> FETCH.
  - If counter reaches ALU_TIMEOUT without ac_load -> ERROR.
  - ac_load outside EXEC is ignored and does not update z_reg.
- STORE: dmem_addr=operand, dmem_we=1 for exactly one cycle, -> FETCH.
- ERROR: err=1, busy=0, alu_control=0. Terminal until rst; start is ignored.
- Latencies: NOP/jump 3 cycles; STORE 4; INC/CLR 3+k; memory ALU ops 4+k (k = cycles until ac_load, k>=1).
- Jump target equal to the jump's own address is legal (infinite loop).

Decomposition:
- Shared package alu_pkg holds:
  - ALU code localparams (ALU_PASS..ALU_CLR);
  - opcode localparams (OP_NOP..OP_HALT);
  - state encoding.
- The ALU itself imports alu_pkg so codes stay consistent.
- One natural sub-module: alu_op_decoder, combinational opcode -> {alu_control, needs_mem, is_alu, is_jump, illegal}.

Test Plan:
- Reset mid-EXEC: assert rst while alu_control=1 -> next cycle alu_control=0, busy=0, err=0, imem_addr=0.
- Program LOAD 0x010 (mem=5), ADD 0x011 (mem=7), STORE 0x012, HALT, with an ALU model giving ac_load one cycle after control. Required response:
  - alu_control sequence 0 then 1;
  - one dmem_we pulse with dmem_addr=0x012;
  - done=1 after 4+1+4+1+4+3 = 17 cycles from start.
- SUB with equal operands (zflag=1 on ac_load), then JMPZ 0x020 -> next imem_addr=0x020. Repeat with zflag=0 -> imem_addr=pc+1.
- JMPNZ not taken at address 0xFFF with z_reg=1 -> next fetch at 0x000 (wrap).
- ALU_TIMEOUT=8, ac_load held low during ADD -> err=1 exactly 8 cycles after EXEC entry. A later start is ignored; rst clears err.
- Opcode 0xB at address 0 -> err=1 on the cycle after DECODE; dmem_we never asserted.
